// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: decodes frames into {released, extended, code} events queued in a FWFT FIFO.
// Optional modifier tracking (alt/ctrl/shift) is compiled in when KBD_MODS_EN is defined.
module ps2_kbd_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int TIMEOUT_MS = 20,
    parameter int DEPTH      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps_clock,
    input  logic       ps_data,
    input  logic       rd,
    output logic [9:0] dout,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       error,
    output logic [2:0] mods
);
    localparam int AW        = $clog2(DEPTH);
    localparam int TMO_LIMIT = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);

    typedef enum logic {IDLE, RECV} state_t;
    state_t state, state_nxt;

    logic [2:0]       ck_sync;
    logic [1:0]       dt_sync;
    logic             fall, bit_in;
    logic [3:0]       bit_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [8:0]       shreg;
    logic [9:0]       frame_word;
    logic             frame_done, frame_ok, timeout;
    logic             released, extended;
    logic             ev_vld;
    logic [9:0]       ev_dat;

    // ck_sync[2] is the previous synchronised sample, used only for edge detection
    assign fall   = ck_sync[2] & ~ck_sync[1];
    assign bit_in = dt_sync[1];

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        timeout    = 1'b0;
        frame_word = {bit_in, shreg};
        frame_ok   = (^frame_word[8:0]) & frame_word[9];
        case (state)
            IDLE: if (fall && !bit_in) state_nxt = RECV;
            RECV: begin
                if (fall && bit_cnt == 4'd9) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ck_sync  <= 3'b111;
            dt_sync  <= 2'b11;
            state    <= IDLE;
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            shreg    <= '0;
            released <= 1'b0;
            extended <= 1'b0;
            ev_vld   <= 1'b0;
            ev_dat   <= '0;
            error    <= 1'b0;
        end else begin
            ck_sync <= {ck_sync[1:0], ps_clock};
            dt_sync <= {dt_sync[0], ps_data};
            state   <= state_nxt;
            ev_vld  <= 1'b0;
            error   <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= '0;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (fall) begin
                    shreg   <= {bit_in, shreg[8:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (frame_done) begin
                if (!frame_ok) begin
                    error    <= 1'b1;
                    released <= 1'b0;
                    extended <= 1'b0;
                end else if (frame_word[7:0] == 8'hF0) begin
                    released <= 1'b1;
                end else if (frame_word[7:0] == 8'hE0) begin
                    extended <= 1'b1;
                end else begin
                    ev_vld   <= 1'b1;
                    ev_dat   <= {released, extended, frame_word[7:0]};
                    released <= 1'b0;
                    extended <= 1'b0;
                end
            end else if (timeout) begin
                error    <= 1'b1;
                released <= 1'b0;
                extended <= 1'b0;
            end
        end
    end

    logic [9:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [9:0]  last_dout;
    logic        push, pop;

    assign pop   = rd && !empty;
    assign push  = ev_vld && (!full || pop);
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    // last_dout keeps the most recently popped head visible once the FIFO drains
    assign dout  = empty ? last_dout : mem[rptr];

    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= ev_dat;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            last_dout <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= ev_vld && full && !pop;
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                rptr      <= rptr + 1'b1;
                last_dout <= mem[rptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef KBD_MODS_EN
    logic [2:0] mods_r;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mods_r <= 3'b000;
        end else if (ev_vld) begin
            case (ev_dat[7:0])
                8'h12, 8'h59: mods_r[0] <= ~ev_dat[9];
                8'h14:        mods_r[1] <= ~ev_dat[9];
                8'h11:        mods_r[2] <= ~ev_dat[9];
                default:      mods_r    <= mods_r;
            endcase
        end
    end
    assign mods = mods_r;
`else
    assign mods = 3'b000;
`endif

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Randomised bench for ps2_kbd_fifo against a queue-based model of the keyboard event stream.
module tb_ps2_kbd_fifo;
    localparam int DEPTH = 8;

    logic       clk, rst, ps_clock, ps_data, rd;
    logic [9:0] dout;
    logic       empty, full, overflow, error;
    logic [2:0] mods;

    int tests_run = 0;
    int tests_failed = 0;

    logic [9:0] exp_q[$];
    bit         rel_m, ext_m;
    logic [2:0] mods_m;
    int err_exp = 0, ovf_exp = 0, err_cnt = 0, ovf_cnt = 0;

    ps2_kbd_fifo #(.CLK_HZ(1000000), .TIMEOUT_MS(1), .DEPTH(DEPTH)) dut (
        .clock(clk), .reset(rst), .ps_clock(ps_clock), .ps_data(ps_data), .rd(rd),
        .dout(dout), .empty(empty), .full(full), .overflow(overflow), .error(error), .mods(mods)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow) ovf_cnt++;
        if (error) err_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic model_reset();
        exp_q.delete();
        rel_m = 0; ext_m = 0; mods_m = 3'b000;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad);
        logic [9:0] ent;
        if (bad) begin
            err_exp++; rel_m = 0; ext_m = 0;
        end else if (b == 8'hF0) begin
            rel_m = 1;
        end else if (b == 8'hE0) begin
            ext_m = 1;
        end else begin
            ent = {rel_m, ext_m, b};
            if (exp_q.size() < DEPTH) exp_q.push_back(ent);
            else ovf_exp++;
`ifdef KBD_MODS_EN
            if (b == 8'h12 || b == 8'h59) mods_m[0] = !rel_m;
            if (b == 8'h14) mods_m[1] = !rel_m;
            if (b == 8'h11) mods_m[2] = !rel_m;
`endif
            rel_m = 0; ext_m = 0;
        end
    endtask

    // Drives one 11-bit frame; samples empty 3 and 4 cycles after the stop-bit falling edge
    // and optionally pops in exactly the cycle the event is written.
    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                         input bit pop_w, output logic e3, output logic e4);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        e3 = 1'bx; e4 = 1'bx;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); ps_data = bits[i];
            repeat (4) @(negedge clk);
            ps_clock = 0;
            if (i == 10) begin
                repeat (3) @(negedge clk);
                e3 = empty;
                if (pop_w) begin
                    tests_run++;
                    if (dout !== exp_q[0]) begin
                        tests_failed++;
                        $display("FAIL pop_on_write_head: got %h required %h", dout, exp_q[0]);
                    end
                    rd = 1;
                end
                @(negedge clk); rd = 0; e4 = empty;
                repeat (6) @(negedge clk);
            end else begin
                repeat (10) @(negedge clk);
            end
            ps_clock = 1;
            repeat (4) @(negedge clk);
        end
        ps_data = 1;
        repeat (5) @(negedge clk);
        if (pop_w) void'(exp_q.pop_front());
        model_byte(b, bad_par | bad_stop);
    endtask

    task automatic do_pop(output logic [9:0] seen);
        @(negedge clk); seen = dout; rd = 1;
        @(negedge clk); rd = 0;
    endtask

    task automatic drain(input string name);
        logic [9:0] seen, want;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            do_pop(seen);
            tests_run++;
            if (seen !== want) begin
                tests_failed++;
                $display("FAIL %s_readback: got %h required %h", name, seen, want);
            end
        end
        @(negedge clk);
        tests_run++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_drained: got empty=%b full=%b required empty=1 full=0", name, empty, full);
        end
    endtask

    function automatic logic [7:0] plain_byte();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == 8'hF0 || b == 8'hE0);
        return b;
    endfunction

    task automatic test_reset();
        tests_run++;
        if (dout !== 10'h000 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
            error !== 1'b0 || mods !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_state: got dout=%h empty=%b full=%b ovf=%b err=%b mods=%b required 000 1 0 0 0 000",
                     dout, empty, full, overflow, error, mods);
        end
    endtask

    task automatic test_single();
        logic e3, e4;
        logic [9:0] seen;
        logic [7:0] b;
        frame(8'h1C, 0, 0, 0, e3, e4);
        tests_run++;
        if (e3 !== 1'b1 || e4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_empty_timing: got empty %b then %b required 1 then 0", e3, e4);
        end
        tests_run++;
        if (dout !== 10'h01C) begin
            tests_failed++;
            $display("FAIL single_dout: got %h required 01c", dout);
        end
        drain("single");
        tests_run++;
        if (dout !== 10'h01C) begin
            tests_failed++;
            $display("FAIL single_hold: got %h required 01c", dout);
        end
        do_pop(seen);
        @(negedge clk);
        tests_run++;
        if (empty !== 1'b1 || dout !== 10'h01C) begin
            tests_failed++;
            $display("FAIL rd_when_empty: got empty=%b dout=%h required 1 01c", empty, dout);
        end
        b = plain_byte();
        frame(b, 0, 0, 0, e3, e4);
        tests_run++;
        if (dout !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL after_empty_rd: got %h required %h", dout, exp_q[0]);
        end
        drain("single2");
    endtask

    task automatic test_prefix();
        logic e3, e4;
        frame(8'hE0, 0, 0, 0, e3, e4);
        frame(8'hF0, 0, 0, 0, e3, e4);
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL prefix_no_event: got empty=%b required 1", empty);
        end
        frame(8'h75, 0, 0, 0, e3, e4);
        tests_run++;
        if (dout !== 10'h375 || exp_q.size() != 1) begin
            tests_failed++;
            $display("FAIL prefix_event: got %h required 375", dout);
        end
        drain("prefix");
    endtask

    task automatic test_overflow(input bit pop_last);
        logic e3, e4;
        int ovf0;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 9; i++) frame(plain_byte(), 0, 0, pop_last && i == 8, e3, e4);
        tests_run++;
        if (full !== 1'b1 || ovf_cnt - ovf0 != (pop_last ? 0 : 1) || ovf_cnt != ovf_exp) begin
            tests_failed++;
            $display("FAIL overflow_pop%0d: got full=%b pulses=%0d required full=1 pulses=%0d",
                     pop_last, full, ovf_cnt - ovf0, pop_last ? 0 : 1);
        end
        drain(pop_last ? "full_pop" : "overflow");
    endtask

    task automatic test_parity_error();
        logic e3, e4;
        int err0;
        err0 = err_cnt;
        frame(8'h1C, 1, 0, 0, e3, e4);
        tests_run++;
        if (err_cnt - err0 != 1 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL parity_error: got pulses=%0d empty=%b required 1 1", err_cnt - err0, empty);
        end
        frame(8'h1C, 0, 0, 0, e3, e4);
        tests_run++;
        if (dout !== 10'h01C || empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_recover: got %h required 01c", dout);
        end
        drain("parity");
    endtask

    task automatic test_timeout();
        logic e3, e4;
        int cyc;
        bit seen;
        seen = 0;
        cyc = 0;
        @(negedge clk); ps_data = 0;
        repeat (4) @(negedge clk);
        ps_clock = 0;
        for (int i = 1; i <= 1500 && !seen; i++) begin
            @(negedge clk);
            if (i == 10) begin ps_clock = 1; ps_data = 1; end
            if (error) begin seen = 1; cyc = i; end
        end
        err_exp++; rel_m = 0; ext_m = 0;
        tests_run++;
        if (!seen || cyc < 990 || cyc > 1015) begin
            tests_failed++;
            $display("FAIL timeout_error: got pulse at cycle %0d (seen=%0d) required about 1000", cyc, seen);
        end
        frame(8'h1C, 0, 0, 0, e3, e4);
        tests_run++;
        if (dout !== 10'h01C || empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_recover: got %h required 01c", dout);
        end
        drain("timeout");
    endtask

    task automatic test_mods();
        logic e3, e4;
        logic [7:0] seq [5] = '{8'h12, 8'hF0, 8'h12, 8'hE0, 8'h14};
        int at [3] = '{0, 2, 4};
        logic [2:0] want [3] = '{3'b001, 3'b000, 3'b010};
        int k;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            frame(seq[i], 0, 0, 0, e3, e4);
            if (k < 3 && at[k] == i) begin
                tests_run++;
`ifdef KBD_MODS_EN
                if (mods !== want[k] || mods !== mods_m) begin
                    tests_failed++;
                    $display("FAIL mods_step%0d: got %b required %b", k, mods, want[k]);
                end
`else
                if (mods !== 3'b000) begin
                    tests_failed++;
                    $display("FAIL mods_off_step%0d: got %b required 000", k, mods);
                end
`endif
                k++;
            end
        end
        drain("mods");
    endtask

    task automatic test_reset_midframe();
        logic e3, e4;
        logic [3:0] bits = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); ps_data = bits[i];
            repeat (4) @(negedge clk); ps_clock = 0;
            repeat (10) @(negedge clk); ps_clock = 1;
            repeat (4) @(negedge clk);
        end
        rst = 1;
        repeat (3) @(negedge clk);
        ps_data = 1;
        rst = 0;
        model_reset();
        repeat (20) @(negedge clk);
        tests_run++;
        if (empty !== 1'b1 || dout !== 10'h000 || mods !== 3'b000) begin
            tests_failed++;
            $display("FAIL midframe_reset: got empty=%b dout=%h mods=%b required 1 000 000", empty, dout, mods);
        end
        frame(8'h2B, 0, 0, 0, e3, e4);
        tests_run++;
        if (dout !== 10'h02B || empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_resume: got %h required 02b", dout);
        end
        drain("midframe");
    endtask

    task automatic test_random();
        logic e3, e4;
        logic [9:0] seen, want;
        logic [7:0] b;
        int pick;
        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0: b = 8'hF0;
                1: b = 8'hE0;
                2: b = 8'h12;
                3: b = 8'h59;
                4: b = 8'h14;
                5: b = 8'h11;
                default: b = 8'($urandom_range(0, 255));
            endcase
            frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
                  exp_q.size() > 0 && $urandom_range(0, 4) == 0, e3, e4);
            tests_run++;
            if (err_cnt != err_exp || ovf_cnt != ovf_exp || empty !== (exp_q.size() == 0) ||
                full !== (exp_q.size() == DEPTH) || (exp_q.size() > 0 && dout !== exp_q[0]) ||
                mods !== mods_m) begin
                tests_failed++;
                $display("FAIL random_%0d: got err=%0d ovf=%0d empty=%b full=%b dout=%h mods=%b required err=%0d ovf=%0d size=%0d head=%h mods=%b",
                         n, err_cnt, ovf_cnt, empty, full, dout, mods, err_exp, ovf_exp,
                         exp_q.size(), exp_q.size() > 0 ? exp_q[0] : 10'h000, mods_m);
            end
            if (exp_q.size() > 0 && $urandom_range(0, 9) < 4) begin
                want = exp_q.pop_front();
                do_pop(seen);
                tests_run++;
                if (seen !== want) begin
                    tests_failed++;
                    $display("FAIL random_pop_%0d: got %h required %h", n, seen, want);
                end
            end
        end
        drain("random");
    endtask

    initial begin
        clk = 0; rst = 1; ps_clock = 1; ps_data = 1; rd = 0;
        model_reset();
        repeat (5) @(negedge clk);
        test_reset();
        rst = 0;
        repeat (5) @(negedge clk);
        test_reset();
        test_single();
        test_prefix();
        test_overflow(0);
        test_overflow(1);
        test_parity_error();
        test_timeout();
        test_mods();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
